// File: rtl/uart_rx_defs.sv
// Shared constants for the oversampling UART receiver: state encodings,
// baud divider and majority-vote sample indices.
package uart_rx_defs;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] BREAK  = 3'd5;

   function automatic int calc_div(input int clk_freq, input int bps, input int os);
      return clk_freq / (bps * os);
   endfunction

   function automatic int mid_lo(input int os);
      return os / 2 - 1;
   endfunction

   function automatic int mid_ctr(input int os);
      return os / 2;
   endfunction

   function automatic int mid_hi(input int os);
      return os / 2 + 1;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the last count.
// A synchronous clear restarts the phase so sampling lines up with a start edge.
module uart_baud_tick #(
   parameter int DIV = 27
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         cnt <= '0;
      else if (clr || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampled UART byte receiver with 3-sample majority vote, false-start
// rejection and framing check. Define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx_oversample import uart_rx_defs::*; #(
   parameter int CLK_FREQ   = 50000000,
   parameter int UART_BPS   = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       uart_rxd,
   output logic [7:0] uart_data,
   output logic       uart_done,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int            DIV    = calc_div(CLK_FREQ, UART_BPS, OVERSAMPLE);
   localparam int            SW     = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] S_LO   = SW'(mid_lo(OVERSAMPLE));
   localparam logic [SW-1:0] S_MID  = SW'(mid_ctr(OVERSAMPLE));
   localparam logic [SW-1:0] S_HI   = SW'(mid_hi(OVERSAMPLE));
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

   logic          rxd_s1, rxd_s2, rxd_prev;
   logic [1:0]    arm;
   logic [2:0]    state;
   logic [SW-1:0] samp_cnt, samp_nxt;
   logic [2:0]    bit_cnt;
   logic [1:0]    votes;
   logic [7:0]    shreg;
   logic          brk_ok;
   logic          tick, start_ok, maj, at_mid, at_end;

`ifdef UART_RX_PARITY_EN
   logic par_bit, par_err_q;
   assign parity_err = par_err_q;
`else
   assign parity_err = 1'b0;
`endif

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .clr     (start_ok),
      .tick    (tick)
   );

   // Synchronizer flops come out of reset high; arm keeps that transient from
   // counting as "line seen high", so a line held low through reset is no start.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rxd_s1   <= 1'b1;
         rxd_s2   <= 1'b1;
         rxd_prev <= 1'b0;
         arm      <= 2'b00;
      end else begin
         rxd_s1   <= uart_rxd;
         rxd_s2   <= rxd_s1;
         arm      <= {arm[0], 1'b1};
         rxd_prev <= arm[1] ? rxd_s2 : 1'b0;
      end
   end

   // Sample index of the current tick; the edge itself is sample 0 of the start bit.
   assign start_ok = (state == IDLE) && rxd_prev && !rxd_s2;
   assign samp_nxt = (samp_cnt == S_LAST) ? '0 : samp_cnt + SW'(1);
   assign at_mid   = tick && (samp_nxt == S_HI);
   assign at_end   = tick && (samp_nxt == '0);
   assign maj      = maj3(votes[0], votes[1], rxd_s2);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         uart_data <= 8'h00;
         uart_done <= 1'b0;
         frame_err <= 1'b0;
         samp_cnt  <= '0;
         bit_cnt   <= 3'd0;
         votes     <= 2'b11;
         shreg     <= 8'h00;
         brk_ok    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit   <= 1'b0;
         par_err_q <= 1'b0;
`endif
      end else begin
         uart_done <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
         if (tick) begin
            samp_cnt <= samp_nxt;
            if (samp_nxt == S_LO)  votes[0] <= rxd_s2;
            if (samp_nxt == S_MID) votes[1] <= rxd_s2;
         end

         case (state)
            IDLE: begin
               if (start_ok) begin
                  state    <= START;
                  busy     <= 1'b1;
                  samp_cnt <= '0;
               end
            end
            START: begin
               if (at_mid && maj) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (at_end) begin
                  state   <= DATA;
                  bit_cnt <= 3'd0;
               end
            end
            DATA: begin
               if (at_mid)
                  shreg <= {maj, shreg[7:1]};
               if (at_end) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (at_mid) par_bit <= maj;
               if (at_end) state <= STOP;
            end
`endif
            STOP: begin
               // Decide at mid stop bit so a back-to-back start edge is not missed.
               if (at_mid) begin
                  if (!maj) begin
                     frame_err <= 1'b1;
                     brk_ok    <= 1'b0;
                     state     <= BREAK;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     if (^{shreg, par_bit}) begin
                        par_err_q <= 1'b1;
                     end else begin
                        uart_data <= shreg;
                        uart_done <= 1'b1;
                     end
`else
                     uart_data <= shreg;
                     uart_done <= 1'b1;
`endif
                  end
               end
            end
            BREAK: begin
               if (!rxd_s2) begin
                  brk_ok <= 1'b0;
               end else if (tick) begin
                  if (brk_ok) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     brk_ok <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: the stimulus side queues expected
// pulses, a negedge monitor pops and checks each pulse the receiver emits.
module tb_uart_rx_oversample;

   localparam int BIT_NOM  = 434;                 // 50 MHz / 115200
   localparam int BIT_FAST = 425;                 // transmitter 2% fast
   localparam int LAT      = 2 + 27 * 153;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       uart_rxd = 1'b1;
   logic [7:0] uart_data;
   logic       uart_done, frame_err, parity_err, busy;

   uart_rx_oversample dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .uart_rxd   (uart_rxd),
      .uart_data  (uart_data),
      .uart_done  (uart_done),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #10 sys_clk = ~sys_clk;

   typedef struct {
      int         kind;      // 0 done, 1 frame_err, 2 parity_err
      logic [7:0] data;
      int         edge_c;
      bit         chk_lat;
   } exp_t;

   exp_t       exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   logic [7:0] last_data = 8'h00;
   logic       done_d = 1'b0, ferr_d = 1'b0, perr_d = 1'b0;

   always @(posedge sys_clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every output pulse must match the head of the queue.
   always @(negedge sys_clk) begin
      if (!sys_rst && (uart_done || frame_err || parity_err)) begin
         int   kind;
         exp_t e;
         kind = uart_done ? 0 : (frame_err ? 1 : 2);
         check("pulse_exclusive", int'(uart_done) + int'(frame_err) + int'(parity_err), 1);
         if (uart_done) check("done_width", done_d, 0);
         if (frame_err) check("ferr_width", ferr_d, 0);
         if (parity_err) check("perr_width", perr_d, 0);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: kind %0d data %0h with nothing expected (cycle %0d)",
                     kind, uart_data, cyc);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_data", uart_data, e.data);
            if (e.chk_lat) begin
               n_tests++;
               if ((cyc - e.edge_c) < LAT - 2 || (cyc - e.edge_c) > LAT + 2) begin
                  n_fail++;
                  $display("FAIL latency: got %0d cycles, expected %0d +/-2", cyc - e.edge_c, LAT);
               end
            end
         end
      end
      done_d <= uart_done;
      ferr_d <= frame_err;
      perr_d <= parity_err;
   end

   task automatic send_byte(input logic [7:0] d, input int bitc, input logic stop_v,
                            input logic par_flip, input bit chk_lat);
      exp_t e;
      @(negedge sys_clk);
      uart_rxd = 1'b0;
      e.edge_c  = cyc;
      e.chk_lat = chk_lat;
      if (!stop_v) begin
         e.kind = 1; e.data = last_data;
      end else if (par_flip) begin
         e.kind = 2; e.data = last_data;
      end else begin
         e.kind = 0; e.data = d; last_data = d;
      end
      exp_q.push_back(e);
      repeat (bitc) @(negedge sys_clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = d[i];
         repeat (bitc) @(negedge sys_clk);
      end
`ifdef UART_RX_PARITY_EN
      uart_rxd = (^d) ^ par_flip;
      repeat (bitc) @(negedge sys_clk);
`endif
      uart_rxd = stop_v;
      repeat (bitc) @(negedge sys_clk);
      uart_rxd = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   logic [7:0] seq [9];

   initial begin
      seq = '{8'hFE, 8'hEF, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

      // Reset state
      idle(4);
      check("rst_data", uart_data, 8'h00);
      check("rst_done", uart_done, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_perr", parity_err, 0);
      check("rst_busy", busy, 0);
      sys_rst = 1'b0;
      idle(20);

      // Nominal byte with latency check
      send_byte(8'hA5, BIT_NOM, 1'b1, 1'b0, 1'b1);
      idle(300);
      check("busy_after_a5", busy, 0);

      // 60-cycle low glitch: accepted edge, then rejected at mid start bit
      uart_rxd = 1'b0;
      idle(40);
      check("glitch_busy_high", busy, 1);
      idle(20);
      uart_rxd = 1'b1;
      idle(600);
      check("glitch_busy_low", busy, 0);

      // Framing error then a good byte
      send_byte(8'h3C, BIT_NOM, 1'b0, 1'b0, 1'b0);
      idle(300);
      check("data_held_after_ferr", uart_data, 8'hA5);
      idle(700);
      send_byte(8'h55, BIT_NOM, 1'b1, 1'b0, 1'b0);
      idle(200);

      // Back-to-back burst, fast transmitter
      for (int i = 0; i < 9; i++)
         send_byte(seq[i], BIT_FAST, 1'b1, 1'b0, 1'b0);
      idle(300);

      // Reset in the middle of 0xFF, released with the line low
      @(negedge sys_clk);
      uart_rxd = 1'b0;
      idle(BIT_NOM);
      uart_rxd = 1'b1;
      idle(BIT_NOM * 4 + BIT_NOM / 2);
      sys_rst  = 1'b1;
      uart_rxd = 1'b0;
      idle(10);
      check("rst_mid_data", uart_data, 8'h00);
      sys_rst = 1'b0;
      last_data = 8'h00;
      idle(100);
      check("busy_line_low_after_rst", busy, 0);
      uart_rxd = 1'b1;
      idle(1500);
      check("busy_idle_after_rst", busy, 0);
      send_byte(8'h12, BIT_NOM, 1'b1, 1'b0, 1'b0);
      idle(300);

`ifdef UART_RX_PARITY_EN
      send_byte(8'h81, BIT_NOM, 1'b1, 1'b1, 1'b0);
      idle(300);
      send_byte(8'h81, BIT_NOM, 1'b1, 1'b0, 1'b0);
      idle(300);
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
